// File: rtl/pri_arbiter_pkg.sv
// Shared definitions for the 8-requester priority arbiter.
package pri_arbiter_pkg;

    localparam int N_REQ = 8;
    localparam int ID_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/pri_arbiter_pick.sv
// Combinational winner search: scans downward from start, wrapping 0 -> 7,
// and reports the first requester found.
module pri_pick
    import pri_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  start,
    output logic             hit,
    output logic [ID_W-1:0]  id
);

    logic [ID_W-1:0] idx;

    // First set bit at or below start, in wrapped descending order
    always_comb begin
        hit = 1'b0;
        id  = '0;
        idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = start - ID_W'(k);
            if (!hit && req[idx]) begin
                hit = 1'b1;
                id  = idx;
            end
        end
    end

endmodule

// File: rtl/pri_arbiter.sv
// Sequential 8-requester arbiter with hold timeout and a one-cycle dead gap
// between grants. Define PRI_ARBITER_RR_EN for rotating (round-robin)
// priority; otherwise req[7] always has the highest priority.
module pri_arbiter
    import pri_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             En,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             v,
    output logic             timeout
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
    logic             timeout_q, timeout_d;
    logic [7:0]       hold_cnt_q, hold_cnt_d;
    logic [N_REQ-1:0] mask_q, mask_d;

    logic             pick_hit;
    logic [ID_W-1:0]  pick_id;
    logic [ID_W-1:0]  pick_start;

`ifdef PRI_ARBITER_RR_EN
    logic [ID_W-1:0]  ptr_q, ptr_d;
    assign pick_start = ptr_q;
`else
    assign pick_start = ID_W'(N_REQ - 1);
`endif

    // mask_q is only non-zero during the GAP cycle that follows a timeout
    pri_pick u_pick (
        .req   (req & ~mask_q),
        .start (pick_start),
        .hit   (pick_hit),
        .id    (pick_id)
    );

    // Next-state and grant logic
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        timeout_d  = 1'b0;
        hold_cnt_d = hold_cnt_q;
        mask_d     = '0;
`ifdef PRI_ARBITER_RR_EN
        ptr_d      = ptr_q;
`endif
        case (state_q)
            IDLE, GAP: begin
                // IDLE and GAP arbitrate identically; GAP differs only by mask_q
                if (En && pick_hit) begin
                    state_d          = BUSY;
                    gnt_d            = '0;
                    gnt_d[pick_id]   = 1'b1;
                    gnt_id_d         = pick_id;
                    hold_cnt_d       = '0;
`ifdef PRI_ARBITER_RR_EN
                    ptr_d            = pick_id - ID_W'(1);
`endif
                end else begin
                    state_d  = IDLE;
                    gnt_d    = '0;
                    gnt_id_d = '0;
                end
            end
            BUSY: begin
                hold_cnt_d = hold_cnt_q + 8'd1;
                if (!En) begin
                    state_d  = IDLE;
                    gnt_d    = '0;
                    gnt_id_d = '0;
                end else if (!req[gnt_id_q]) begin
                    state_d  = GAP;
                    gnt_d    = '0;
                    gnt_id_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d          = GAP;
                    gnt_d            = '0;
                    gnt_id_d         = '0;
                    timeout_d        = 1'b1;
                    mask_d[gnt_id_q] = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            timeout_q  <= 1'b0;
            hold_cnt_q <= '0;
            mask_q     <= '0;
`ifdef PRI_ARBITER_RR_EN
            ptr_q      <= ID_W'(N_REQ - 1);
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            timeout_q  <= timeout_d;
            hold_cnt_q <= hold_cnt_d;
            mask_q     <= mask_d;
`ifdef PRI_ARBITER_RR_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign v       = |gnt_q;
    assign timeout = timeout_q;

endmodule

// File: doc/pri_arbiter.md
# pri_arbiter

Sequential 8-requester arbiter that shares one resource (bus, encoder datapath, shared register port) among eight requesters. Grants are chosen in the priority-encoder order used across the design: `req[7]` highest, `req[0]` lowest. Each grant is held until its requester releases or a hold timeout expires. An optional round-robin mode rotates priority for fairness.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive grant cycles per request; legal range 2..255.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous reset, active-high.
- `En`  in  1: arbitration enable. Low blocks new grants and revokes any current grant.
- `req`  in  8: request vector; requester i holds `req[i]` high while it wants or uses the resource.
- `gnt`  out  8: one-hot grant, registered.
- `gnt_id`  out  3: binary index of the granted requester; 3'b000 when `v`=0, never X.
- `v`  out  1: grant valid, equal to `|gnt`.
- `timeout`  out  1: one-cycle pulse when a grant is forcibly revoked by the hold limit.

## Operation
- States:
  - IDLE: no grant.
  - BUSY: grant held.
  - GAP: one dead cycle after a release or timeout.
- IDLE: if `En`=1 and `req`≠0, pick the winner, load `gnt`/`gnt_id`, set `v`=1, clear `hold_cnt`, go to BUSY. Otherwise stay in IDLE with outputs zero.
- BUSY: `hold_cnt` increments every cycle. Exits are evaluated in priority order:
  1. `En`=0: go to IDLE, clear outputs, no `timeout`.
  2. `req[gnt_id]`=0 (release): go to GAP, clear outputs.
  3. `hold_cnt`==MAX_HOLD-1 with `req[gnt_id]` still high: go to GAP, clear outputs, set `timeout`=1 for one cycle, record the masked index.
  4. None of the above: stay in BUSY.
- GAP: `gnt`=0 for exactly one cycle. Arbitration runs in the same cycle with the timed-out requester masked; the mask applies only to this cycle and is cleared otherwise. Next state is BUSY on a winner, otherwise IDLE. If `En`=0, go to IDLE.
- Winner selection is combinational over `req & ~mask`. With every bit masked, there is no winner.
- Changes on non-granted `req` bits during BUSY have no effect.
- Reset values:
  - state = IDLE
  - `gnt` = 0, `gnt_id` = 0, `v` = 0, `timeout` = 0
  - `hold_cnt` = 0, mask = 0
  - rotate pointer = 7

## Timing
- Request-to-grant latency is 1 cycle: `req` sampled at edge k gives `gnt` valid after edge k.
- Release-to-next-grant is 2 edges: the edge that drops `gnt`, then the GAP edge that loads the new `gnt`.
- A single grant lasts at most MAX_HOLD cycles.
- `timeout` is high during the first GAP cycle only.
- When release and the hold limit coincide, release wins and no `timeout` is raised. When `En`=0 coincides with either, `En` wins.
- `rst` asserted mid-grant clears all outputs immediately (asynchronously). Arbitration resumes on the first edge after deassertion.
- `hold_cnt` width is 8 bits and never wraps, because it is cleared on every BUSY entry.

## Configuration
- Macro: `PRI_ARBITER_RR_EN`.
- Undefined: fixed priority, 7 > 6 > … > 0. The rotate pointer is absent.
- Defined: round-robin. The search starts at the rotate pointer and proceeds downward, wrapping 0→7. After a grant to index i, pointer ← (i−1) mod 8 (i=0 gives 7). The pointer updates only when a grant is issued. The reset value of 7 makes the first arbitration identical to fixed priority.

## Structure
- Shared package `pri_arbiter_pkg` holds:
  - `N_REQ`=8, `ID_W`=3
  - state enum `arb_state_t` {IDLE, BUSY, GAP}
- Sub-module `pri_pick`: combinational pick with ports `req[7:0]`, `start[2:0]`, `hit`, and `id[2:0]`. It searches downward from `start` with wrap. The fixed-priority build ties `start` to 3'd7.

## Test plan
- Reset, then `req`=8'h00 for 5 cycles: `gnt`=0, `gnt_id`=0, `v`=0 throughout.
- `req`=8'b1010_0100: `gnt`=8'h80 and `gnt_id`=7 one cycle later. Drop `req[7]`: one GAP cycle, then `gnt`=8'h20, `gnt_id`=5.
- MAX_HOLD=4, `req[3]` held forever: `gnt`=8'h08 for exactly 4 cycles, then `timeout` pulse and a GAP cycle. With `req[1]` also high, the next grant goes to 1, not 3.
- Requester 6 granted, `En` dropped mid-grant: `gnt`=0 next cycle, state IDLE, no `timeout`. Re-raise `En`: grant returns to 6 after 1 cycle.
- With `PRI_ARBITER_RR_EN` defined, `req`=8'hFF and each grant released after 1 cycle: grant order 7,6,5,…,0,7.
- `rst` pulsed while BUSY on index 2: outputs clear without a clock edge. The first post-reset grant follows fixed order.
